// File: rtl/data_bus_arbiter.sv
// Round-robin master arbiter with base/mask slave decode, ack timeout and error termination.
// States: IDLE arbitrate + decode | BUSY slave selected, waiting for ack | RESP one-cycle ack to master
module data_bus_arbiter #(
  parameter int NMST = 2,
  parameter int NSLV = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 22,
  parameter logic [NSLV-1:0][MASK_W-1:0] BADR = {22'h0F0000, 22'h001000, 22'h000000},
  parameter logic [NSLV-1:0][MASK_W-1:0] MADR = {22'h3F0000, 22'h3FF000, 22'h3FF000},
  parameter logic [NSLV-1:0] SLV_MASK = '1,
  parameter logic [NMST-1:0] MST_MASK = '1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NMST-1:0]            m_req,
  input  logic [NMST*ADDR_W-1:0]     m_addr,
  input  logic [NMST-1:0]            m_we,
  input  logic [NMST*(DATA_W/8)-1:0] m_be,
  input  logic [NMST*DATA_W-1:0]     m_wdata,
  output logic [NMST-1:0]            m_grant,
  output logic [NMST-1:0]            m_ack,
  output logic                       m_err,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [NSLV-1:0]            s_sel,
  output logic [ADDR_W-1:0]          s_addr,
  output logic                       s_we,
  output logic [DATA_W/8-1:0]        s_be,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [NSLV-1:0]            s_ack,
  input  logic [NSLV*DATA_W-1:0]     s_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  last_q;
  logic [NSLV-1:0]   sel_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic [NMST-1:0]   elig;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic [MASK_W-1:0] win_low;
  logic [NSLV-1:0]   dec;
  logic [DATA_W-1:0] sel_rdata;
  logic              ack_hit;
  logic              tmo_hit;

  // Round-robin: scan upward from the index after the last grant, wrapping.
  always_comb begin
    elig      = m_req & MST_MASK;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NMST; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NMST);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    win_low = '0;
    for (int m = 0; m < NMST; m++) begin
      if (win_idx == IDX_W'(m)) win_low = m_addr[m*ADDR_W +: MASK_W];
    end
    dec = '0;
    for (int s = NSLV - 1; s >= 0; s--) begin
      if (SLV_MASK[s] && ((win_low & MADR[s]) == BADR[s])) begin
        dec    = '0;
        dec[s] = 1'b1;
      end
    end
  end

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_wdata = '0;
    if (state == BUSY) begin
      for (int m = 0; m < NMST; m++) begin
        if (m_grant[m]) begin
          s_addr  = m_addr[m*ADDR_W +: ADDR_W];
          s_we    = m_we[m];
          s_be    = m_be[m*BE_W +: BE_W];
          s_wdata = m_wdata[m*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < NSLV; s++) begin
      if (sel_q[s]) sel_rdata = s_rdata[s*DATA_W +: DATA_W];
    end
  end

  assign ack_hit = |(s_ack & sel_q);
  assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));
  assign s_sel   = (state == BUSY) ? sel_q : '0;
  assign m_ack   = (state == RESP) ? m_grant : '0;
  assign m_err   = (state == RESP) && err_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (win_found) state_nx = (|dec) ? BUSY : RESP;
      BUSY: if (ack_hit || tmo_hit) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_q   <= IDX_W'(NMST - 1);
      m_grant  <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      m_rdata  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (win_found) begin
            m_grant <= NMST'(1) << win_idx;
            last_q  <= win_idx;
            sel_q   <= dec;
            err_q   <= ~|dec;
            if (~|dec) m_rdata <= '0;
          end
        end
        BUSY: begin
          // An ack arriving on the expiry cycle still counts as success.
          if (ack_hit) begin
            m_rdata <= sel_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            m_rdata <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          m_grant  <= '0;
          sel_q    <= '0;
          err_q    <= 1'b0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized bench: masters and slaves driven with $urandom, each transaction's timeline predicted
// from the address map, round-robin order and ack delay, then compared cycle by cycle.
module tb_data_bus_arbiter;

  localparam int NMST = 3;
  localparam int NSLV = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int TMO  = 6;
  localparam logic [NMST-1:0] MMASK = 3'b011;
  localparam logic [NSLV-1:0] SMASK = 3'b101;

  logic clk = 1'b0;
  logic rst_n;
  logic [NMST-1:0]    m_req;
  logic [NMST*AW-1:0] m_addr;
  logic [NMST-1:0]    m_we;
  logic [NMST*BW-1:0] m_be;
  logic [NMST*DW-1:0] m_wdata;
  logic [NMST-1:0]    m_grant;
  logic [NMST-1:0]    m_ack;
  logic               m_err;
  logic [DW-1:0]      m_rdata;
  logic [NSLV-1:0]    s_sel;
  logic [AW-1:0]      s_addr;
  logic               s_we;
  logic [BW-1:0]      s_be;
  logic [DW-1:0]      s_wdata;
  logic [NSLV-1:0]    s_ack;
  logic [NSLV*DW-1:0] s_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_m, free_at, sel_cnt;
  int post_rst_cyc = -1;
  bit tx_valid, tx_err, did_reset;
  int tx_owner, tx_slv, tx_g, tx_a, tx_d;
  logic [DW-1:0] tx_rdata;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .NMST(NMST), .NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW), .MASK_W(22),
    .SLV_MASK(SMASK), .MST_MASK(MMASK), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_grant(m_grant), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Address map as plain ranges: IMEM 4 KiB at 0, DMEM 4 KiB at 0x1000, LED 64 KiB at 0xF0000.
  function automatic int model_decode(logic [AW-1:0] addr);
    int a;
    a = int'(addr & 32'h003F_FFFF);
    if (a < 'h1000) return SMASK[0] ? 0 : -1;
    if (a < 'h2000) return SMASK[1] ? 1 : -1;
    if ((a >> 16) == 'hF) return SMASK[2] ? 2 : -1;
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [21:0] lo;
    logic [AW-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       lo = 22'($urandom_range(0, 'hFFF));
      1:       lo = 22'('h1000 + $urandom_range(0, 'hFFF));
      2:       lo = 22'('hF0000 + $urandom_range(0, 'hFFFF));
      default: lo = 22'('h200000 + $urandom_range(0, 'h1FFFFF));
    endcase
    return {r[AW-1:22], lo};
  endfunction

  task automatic new_req(int m);
    m_req[m] = 1'b1;
    m_addr[m*AW +: AW]  = rand_addr();
    m_we[m]             = 1'($urandom_range(0, 1));
    m_be[m*BW +: BW]    = 4'($urandom_range(0, 15));
    m_wdata[m*DW +: DW] = $urandom;
  endtask

  task automatic check_reset(string pfx);
    check({pfx, "_grant"}, m_grant, '0);
    check({pfx, "_ack"}, m_ack, '0);
    check({pfx, "_err"}, m_err, '0);
    check({pfx, "_rdata"}, m_rdata, '0);
    check({pfx, "_sel"}, s_sel, '0);
    check({pfx, "_s_addr"}, s_addr, '0);
    check({pfx, "_s_we"}, s_we, '0);
    check({pfx, "_s_be"}, s_be, '0);
    check({pfx, "_s_wdata"}, s_wdata, '0);
  endtask

  task automatic check_outputs();
    bit in_tx;
    logic [NMST-1:0] eg, ea;
    logic [NSLV-1:0] es;
    in_tx = tx_valid && cyc >= tx_g && cyc <= tx_a;
    eg = in_tx ? NMST'(1) << tx_owner : '0;
    es = (in_tx && cyc < tx_a && tx_slv >= 0) ? NSLV'(1) << tx_slv : '0;
    ea = (tx_valid && cyc == tx_a) ? NMST'(1) << tx_owner : '0;
    check("m_grant", m_grant, eg);
    check("s_sel", s_sel, es);
    check("m_ack", m_ack, ea);
    if (es != '0) begin
      check("s_addr", s_addr, m_addr[tx_owner*AW +: AW]);
      check("s_we", s_we, m_we[tx_owner]);
      check("s_be", s_be, m_be[tx_owner*BW +: BW]);
      check("s_wdata", s_wdata, m_wdata[tx_owner*DW +: DW]);
    end
    if (ea != '0) begin
      check("m_err", m_err, tx_err);
      if (tx_slv >= 0) check("m_rdata", m_rdata, tx_err ? '0 : tx_rdata);
    end
    if (cyc == post_rst_cyc) check("post_rst_grant", m_grant, 3'b001);
  endtask

  task automatic drive_masters();
    for (int m = 0; m < NMST; m++) begin
      if (!MMASK[m]) begin
        if ($urandom_range(0, 1) == 1) new_req(m);
        else m_req[m] = 1'b0;
      end else if (tx_valid && cyc == tx_a && m == tx_owner) begin
        if ($urandom_range(0, 1) == 1) new_req(m);
        else m_req[m] = 1'b0;
      end else if (!m_req[m] && $urandom_range(0, 2) == 0) begin
        new_req(m);
      end
    end
  endtask

  // Selected slave acks after tx_d selected cycles; unselected slaves toggle ack randomly.
  task automatic drive_slaves();
    if (s_sel == '0) sel_cnt = 0;
    for (int s = 0; s < NSLV; s++) begin
      s_rdata[s*DW +: DW] = $urandom;
      if (s_sel[s]) begin
        sel_cnt++;
        s_ack[s] = (sel_cnt == tx_d);
        if (sel_cnt == tx_d) tx_rdata = s_rdata[s*DW +: DW];
      end else begin
        s_ack[s] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic arbitrate();
    bit found;
    int j;
    found = 1'b0;
    if (cyc >= free_at) begin
      for (int i = 1; i <= NMST; i++) begin
        j = (last_m + i) % NMST;
        if (!found && m_req[j] && MMASK[j]) begin
          found    = 1'b1;
          tx_valid = 1'b1;
          tx_owner = j;
          last_m   = j;
          tx_g     = cyc + 1;
          tx_slv   = model_decode(m_addr[j*AW +: AW]);
          tx_rdata = '0;
          if (tx_slv < 0) begin
            tx_d   = 0;
            tx_err = 1'b1;
            tx_a   = tx_g;
          end else begin
            tx_d   = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, TMO + 2));
            tx_err = (tx_d > TMO + 1);
            tx_a   = tx_g + (tx_err ? TMO + 1 : tx_d);
          end
          free_at = tx_a + 1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    s_ack = '0; s_rdata = '0;
    last_m = NMST - 1; free_at = 0; sel_cnt = 0;
    tx_valid = 1'b0; did_reset = 1'b0; tx_d = 0; tx_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      check_outputs();
      if (!did_reset && cyc > 1500 && tx_valid && tx_slv >= 0 && cyc >= tx_g && cyc < tx_a) begin
        rst_n = 1'b0;
        m_req = '0;
        s_ack = '0;
        @(negedge clk);
        cyc++;
        check_reset("mid_rst");
        rst_n = 1'b1;
        tx_valid = 1'b0; last_m = NMST - 1; free_at = cyc; sel_cnt = 0;
        did_reset = 1'b1;
        post_rst_cyc = cyc + 1;
        new_req(0);
        new_req(1);
        drive_slaves();
        arbitrate();
      end else begin
        drive_masters();
        drive_slaves();
        arbitrate();
      end
      @(negedge clk);
      cyc++;
    end
    if (!did_reset) begin
      n_errors++;
      $display("FAIL mid_reset: no busy window found before cycle %0d", cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
